// File: rtl/md_defs_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - op encodings for mult/multu/div/divu and their width
//   - FSM state encodings
//   - default busy latencies
package md_defs_pkg;

  localparam int MD_OP_W = 2;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // div/divu share the high op bit
  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational mult/div datapath.
// Ports:
//   op       in  2   operation (mult/multu/div/divu)
//   a, b     in  32  operands
//   res_hi   out 32  product high word / remainder
//   res_lo   out 32  product low word / quotient
//   div_zero out 1   div/divu with b==0 (caller must not commit)
module md_calc
  import md_defs_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic [31:0]        res_hi,
  output logic [31:0]        res_lo,
  output logic               div_zero
);

  logic [63:0]        w_sprod;
  logic [63:0]        w_uprod;
  logic               w_bzero;
  logic               w_ovf;
  logic [31:0]        w_b_safe;
  logic signed [31:0] w_squo;
  logic signed [31:0] w_srem;
  logic [31:0]        w_uquo;
  logic [31:0]        w_urem;

  // Low 64 bits of a 64x64 product of sign-extended operands is the
  // exact signed 32x32 product.
  assign w_sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_uprod = {32'd0, a} * {32'd0, b};

  assign w_bzero = (b == 32'd0);
  assign w_ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Substituting divisor 1 for both corners keeps the divider defined:
  // for the overflow case it yields exactly lo=a=0x80000000, hi=0.
  assign w_b_safe = (w_bzero || w_ovf) ? 32'd1 : b;

  // Signed '/' truncates toward zero and '%' follows the dividend's sign.
  assign w_squo = $signed(a) / $signed(w_b_safe);
  assign w_srem = $signed(a) % $signed(w_b_safe);
  assign w_uquo = a / (w_bzero ? 32'd1 : b);
  assign w_urem = a % (w_bzero ? 32'd1 : b);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = w_sprod;
      MD_MULTU: {res_hi, res_lo} = w_uprod;
      MD_DIV:   begin res_lo = w_squo; res_hi = w_srem; end
      MD_DIVU:  begin res_lo = w_uquo; res_hi = w_urem; end
      default:  ;
    endcase
  end

  assign div_zero = md_is_div(op) && w_bzero;

endmodule

// File: rtl/md_sequencer.sv
// Execute-stage multiply/divide sequencer.
// Latches the result on issue, holds the unit busy for a fixed latency,
// then commits to HI/LO. Requests a pipeline stall while a D-stage HI/LO
// instruction would collide with an in-flight operation.
// Ports:
//   clk, reset(active low, async)
//   start/op/a/b   issue of mult/multu/div/divu from E
//   hi_we/lo_we    mthi/mtlo from E, data on wdata
//   d_md_instr     D-stage instruction touches HI/LO
//   busy           operation in flight
//   md_stall       stall request to the hazard unit
//   hi/lo          architectural HI/LO
module md_sequencer
  import md_defs_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [31:0]        wdata,
  input  logic               d_md_instr,
  output logic               busy,
  output logic               md_stall,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  md_state_e        r_state;
  md_state_e        w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_dz;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_div_zero;
  logic             w_last;

  md_calc u_calc (
    .op       (op),
    .a        (a),
    .b        (b),
    .res_hi   (w_res_hi),
    .res_lo   (w_res_lo),
    .div_zero (w_div_zero)
  );

  // Counter reaches 0 on this edge: commit and return to IDLE.
  assign w_last = (r_state == MD_RUN) && (r_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= MD_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      MD_IDLE: if (start)  w_next_state = MD_RUN;
      MD_RUN:  if (w_last) w_next_state = MD_IDLE;
      default:             w_next_state = MD_IDLE;
    endcase
  end

  // Outputs; the start term covers the issuing instruction's own E cycle.
  always_comb begin
    busy     = (r_state == MD_RUN);
    md_stall = d_md_instr && (start || (r_state == MD_RUN));
  end

  // Counter, pending result and architectural HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_dz <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (r_state == MD_IDLE) begin
      if (start) begin
        // start wins over a same-cycle move; the move is dropped
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_dz <= w_div_zero;
        r_cnt     <= md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end else begin
      // RUN: issues and moves are ignored
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last && !r_pend_dz) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        hi_we, lo_we, d_md_instr;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  md_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .d_md_instr (d_md_instr),
    .busy       (busy),
    .md_stall   (md_stall),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then back to the falling edge for drive/sample.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    wdata = '0; hi_we = 1'b0; lo_we = 1'b0; d_md_instr = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, md_stall}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    d_md_instr = 1'b0;
    reset = 1'b1;
    step();

    // mult -2*3: busy 5 cycles, HI/LO hold old values meanwhile
    issue(2'd0, 32'hFFFF_FFFE, 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("mult_busy", {31'd0, busy}, 32'd1);
      chk("mult_hold_hi", hi, 32'd0);
      chk("mult_hold_lo", lo, 32'd0);
      step();
    end
    chk("mult_done", {31'd0, busy}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // divu 100/7 with D-stage HI/LO instruction: 11 stall cycles
    d_md_instr = 1'b1;
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
    #1 chk("divu_stall_start", {31'd0, md_stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("divu_stall_busy", {31'd0, md_stall}, 32'd1);
      step();
    end
    chk("divu_stall_end", {31'd0, md_stall}, 32'd0);
    chk("divu_busy_end", {31'd0, busy}, 32'd0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    d_md_instr = 1'b0;

    // Signed div -7/2
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    repeat (10) step();
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    // Signed overflow
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (10) step();
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    // Divide by zero: full busy period, HI/LO unchanged
    issue(2'd2, 32'd5, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("dz_busy", {31'd0, busy}, 32'd1);
      step();
    end
    chk("dz_done", {31'd0, busy}, 32'd0);
    chk("dz_lo", lo, 32'h8000_0000);
    chk("dz_hi", hi, 32'd0);

    // mthi in IDLE
    hi_we = 1'b1; wdata = 32'h1234_5678;
    step();
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_lo", lo, 32'h8000_0000);

    // mtlo while busy is ignored
    issue(2'd0, 32'd3, 32'd4);
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    lo_we = 1'b0;
    chk("mtlo_busy_lo", lo, 32'h8000_0000);
    repeat (4) step();
    chk("mtlo_busy_commit_lo", lo, 32'd12);
    chk("mtlo_busy_commit_hi", hi, 32'd0);

    // start + mtlo same cycle: move dropped
    lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    issue(2'd1, 32'd2, 32'd5);
    lo_we = 1'b0;
    chk("start_lowe_busy", {31'd0, busy}, 32'd1);
    chk("start_lowe_lo", lo, 32'd12);
    repeat (5) step();
    chk("start_lowe_commit_lo", lo, 32'd10);

    // Reset during busy cycle 3 of a mult
    issue(2'd0, 32'd9, 32'd9);
    step();
    step();
    chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    issue(2'd1, 32'hFFFF_FFFF, 32'd2);
    repeat (5) step();
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // Back-to-back: mult 6*7 then div 42/5 in first IDLE cycle
    issue(2'd0, 32'd6, 32'd7);
    repeat (5) step();
    chk("b2b_first_busy", {31'd0, busy}, 32'd0);
    chk("b2b_first_lo", lo, 32'd42);
    chk("b2b_first_hi", hi, 32'd0);
    issue(2'd2, 32'd42, 32'd5);
    chk("b2b_second_busy", {31'd0, busy}, 32'd1);
    repeat (9) step();
    chk("b2b_still_busy", {31'd0, busy}, 32'd1);
    chk("b2b_hold_lo", lo, 32'd42);
    step();
    chk("b2b_second_done", {31'd0, busy}, 32'd0);
    chk("b2b_second_lo", lo, 32'd8);
    chk("b2b_second_hi", hi, 32'd2);
    step();
    chk("b2b_no_dup_busy", {31'd0, busy}, 32'd0);
    chk("b2b_no_dup_lo", lo, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
